mt_slave_status: RTL and testbench



---
 rtl/mt_ds_pkg.sv | 32 +++
 rtl/mt_slv_chg.sv | 46 ++++
 rtl/mt_slave_status.sv | 215 +++++++++++++++++++++
 tb/tb_mt_slave_status.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_ds_pkg.sv
// ---------------------------------------------------------------------------
// mt_ds_pkg
// Shared definitions for the MT drive-status (MTDS) generator:
//   - bit positions of every field in the 16-bit mtDS read value
//   - the motion sequencer state type
// ---------------------------------------------------------------------------
package mt_ds_pkg;

    localparam int DS_ATA  = 15;
    localparam int DS_ERR  = 14;
    localparam int DS_PIP  = 13;
    localparam int DS_MOL  = 12;
    localparam int DS_WRL  = 11;
    localparam int DS_EOT  = 10;
    localparam int DS_ZERO = 9;
    localparam int DS_DPR  = 8;
    localparam int DS_DRY  = 7;
    localparam int DS_SSC  = 6;
    localparam int DS_PES  = 5;
    localparam int DS_SDWN = 4;
    localparam int DS_IDB  = 3;
    localparam int DS_TM   = 2;
    localparam int DS_BOT  = 1;
    localparam int DS_SLA  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        SLOW = 2'd2
    } motion_state_t;

endpackage

// File: rtl/mt_slv_chg.sv
// ---------------------------------------------------------------------------
// mt_slv_chg
// Per-slave attention tracker. Keeps a registered copy of the slave's
// medium-on-line line and latches a pending flag on any change of it.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   clr   synchronous clear of the pending flag (wins over a coincident change)
//   in    sMOL bit of this slave
//   pend  pending slave-status-change flag
// ---------------------------------------------------------------------------
module mt_slv_chg
    import mt_ds_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in,
    output logic pend
);

    logic r_copy;
    logic r_primed;   // copy holds a real sample; suppresses a false change after reset
    logic r_pend;

    // NOTE: state flops are written with non-blocking assignments so every
    // flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_copy   <= 1'b0;
            r_primed <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_copy   <= in;
            r_primed <= 1'b1;
            if (clr) begin
                r_pend <= 1'b0;
            end else if (r_primed && (in != r_copy)) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign pend = r_pend;

endmodule

// File: rtl/mt_slave_status.sv
// ---------------------------------------------------------------------------
// mt_slave_status
// TM03-style drive status (MTDS) generator for an MT formatter serving
// NUM_SLAVES transports: motion sequencer (DRY/PIP/SDWN), per-slave
// attention (SSC/SLA), tape-mark / ID-burst latches, ATA and the
// register-modification-refused pulse.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mtINIT              synchronous clear of all state
//   mtCLRATA, mtDRVCLR  attention clear / drive clear pulses
//   mtGO, mtGOPOS       command accept pulse, positioning qualifier
//   mtDONE              motion-complete pulse
//   mtTMDET, mtIDBDET   tape-mark / PE ID-burst detected pulses
//   mtSEL               selected slave
//   sMOL..sDPR          per-slave transport status lines
//   mtER                error register (ERR = any bit set)
//   mtDS                16-bit drive status read value
//   mtRMR               one-clock pulse: mtGO refused while not ready
// ---------------------------------------------------------------------------
module mt_slave_status
    import mt_ds_pkg::*;
#(
    parameter int NUM_SLAVES  = 8,
    parameter int SDWN_CYCLES = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mtINIT,
    input  logic                          mtCLRATA,
    input  logic                          mtDRVCLR,
    input  logic                          mtGO,
    input  logic                          mtGOPOS,
    input  logic                          mtDONE,
    input  logic                          mtTMDET,
    input  logic                          mtIDBDET,
    input  logic [$clog2(NUM_SLAVES)-1:0] mtSEL,
    input  logic [NUM_SLAVES-1:0]         sMOL,
    input  logic [NUM_SLAVES-1:0]         sWRL,
    input  logic [NUM_SLAVES-1:0]         sBOT,
    input  logic [NUM_SLAVES-1:0]         sEOT,
    input  logic [NUM_SLAVES-1:0]         sPES,
    input  logic [NUM_SLAVES-1:0]         sDPR,
    input  logic [15:0]                   mtER,
    output logic [15:0]                   mtDS,
    output logic                          mtRMR
);

    localparam int                SEL_W     = $clog2(NUM_SLAVES);
    localparam int                CNT_W     = $clog2(SDWN_CYCLES + 1);
    localparam logic [CNT_W-1:0]  SDWN_LOAD = CNT_W'(SDWN_CYCLES - 1);

    // ---------------- motion sequencer ----------------
    motion_state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_pip, w_pip_nxt;
    logic              w_go_ok;      // mtGO accepted this clock
    logic              w_pos_done;   // positioning command completed

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pip_nxt   = r_pip;
        w_go_ok     = 1'b0;
        w_pos_done  = 1'b0;
        case (r_state)
            IDLE: if (mtGO) begin
                w_state_nxt = BUSY;
                w_pip_nxt   = mtGOPOS;
                w_go_ok     = 1'b1;
            end
            BUSY: if (mtDONE) begin
                w_state_nxt = SLOW;
                w_cnt_nxt   = SDWN_LOAD;
                w_pip_nxt   = 1'b0;
                w_pos_done  = r_pip;
            end
            SLOW: begin
                // Loaded with SDWN_CYCLES-1, so leaving on zero gives
                // exactly SDWN_CYCLES clocks in SLOW.
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (mtINIT) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_pip_nxt   = 1'b0;
            w_go_ok     = 1'b0;
            w_pos_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pip   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pip   <= w_pip_nxt;
        end
    end

    // ---------------- per-slave attention ----------------
    logic [NUM_SLAVES-1:0] w_pend;
    logic                  w_pend_clr;

    assign w_pend_clr = mtCLRATA | mtDRVCLR | mtINIT;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
        mt_slv_chg u_chg (
            .clk  (clk),
            .rst  (rst),
            .clr  (w_pend_clr),
            .in   (sMOL[g]),
            .pend (w_pend[g])
        );
    end

    // ---------------- latches, ATA, RMR ----------------
    logic w_err, w_ssc, w_flag_clr, w_ata_clr, w_ata_set;
    logic r_tm, r_idb, r_ata, r_last_err, r_last_ssc, r_rmr;

    assign w_err      = |mtER;
    assign w_ssc      = |w_pend;
    assign w_flag_clr = w_go_ok | mtDRVCLR | mtINIT;
    assign w_ata_clr  = mtCLRATA | mtDRVCLR | mtINIT;
    // Edge-triggered so a held ERR or SSC raises attention only once.
    assign w_ata_set  = (w_err & ~r_last_err) | (w_ssc & ~r_last_ssc) | w_pos_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tm       <= 1'b0;
            r_idb      <= 1'b0;
            r_ata      <= 1'b0;
            r_last_err <= 1'b0;
            r_last_ssc <= 1'b0;
            r_rmr      <= 1'b0;
        end else if (mtINIT) begin
            r_tm       <= 1'b0;
            r_idb      <= 1'b0;
            r_ata      <= 1'b0;
            r_last_err <= 1'b0;
            r_last_ssc <= 1'b0;
            r_rmr      <= 1'b0;
        end else begin
            r_last_err <= w_err;
            r_last_ssc <= w_ssc;
            r_rmr      <= mtGO && (r_state != IDLE);

            if (w_flag_clr)    r_tm <= 1'b0;
            else if (mtTMDET)  r_tm <= 1'b1;

            if (w_flag_clr)    r_idb <= 1'b0;
            else if (mtIDBDET) r_idb <= 1'b1;

            if (w_ata_clr)      r_ata <= 1'b0;
            else if (w_ata_set) r_ata <= 1'b1;
        end
    end

    assign mtRMR = r_rmr;

    // ---------------- status word ----------------
    logic w_mol, w_wrl, w_eot, w_bot, w_pes, w_dpr, w_sla;

    // Out-of-range mtSEL matches no slave, so all indexed bits read 0.
    always_comb begin
        w_mol = 1'b0;
        w_wrl = 1'b0;
        w_eot = 1'b0;
        w_bot = 1'b0;
        w_pes = 1'b0;
        w_dpr = 1'b0;
        w_sla = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (mtSEL == SEL_W'(i)) begin
                w_mol = sMOL[i];
                w_wrl = sWRL[i];
                w_eot = sEOT[i];
                w_bot = sBOT[i];
                w_pes = sPES[i];
                w_dpr = sDPR[i];
                w_sla = w_pend[i];
            end
        end
    end

    always_comb begin
        mtDS          = '0;
        mtDS[DS_ATA]  = r_ata;
        mtDS[DS_ERR]  = w_err;
        mtDS[DS_PIP]  = r_pip;
        mtDS[DS_MOL]  = w_mol;
        mtDS[DS_WRL]  = w_wrl;
        mtDS[DS_EOT]  = w_eot;
        mtDS[DS_DPR]  = w_dpr;
        mtDS[DS_DRY]  = (r_state == IDLE);
        mtDS[DS_SSC]  = w_ssc;
        mtDS[DS_PES]  = w_pes;
        mtDS[DS_SDWN] = (r_state == SLOW);
        mtDS[DS_IDB]  = r_idb;
        mtDS[DS_TM]   = r_tm;
        mtDS[DS_BOT]  = w_bot;
        mtDS[DS_SLA]  = w_sla;
    end

endmodule

// File: tb/tb_mt_slave_status.sv
// ---------------------------------------------------------------------------
// tb_mt_slave_status
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model of the drive status word kept in this bench.
// ---------------------------------------------------------------------------
module tb_mt_slave_status;
    import mt_ds_pkg::*;

    localparam int N  = 8;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mtINIT = 1'b0, mtCLRATA = 1'b0, mtDRVCLR = 1'b0;
    logic        mtGO = 1'b0, mtGOPOS = 1'b0, mtDONE = 1'b0;
    logic        mtTMDET = 1'b0, mtIDBDET = 1'b0;
    logic [2:0]  mtSEL = 3'd0;
    logic [7:0]  sMOL = 8'h01, sWRL = 8'h00, sBOT = 8'h00;
    logic [7:0]  sEOT = 8'h00, sPES = 8'h00, sDPR = 8'hFF;
    logic [15:0] mtER = 16'h0000;
    logic [15:0] mtDS;
    logic        mtRMR;

    mt_slave_status #(.NUM_SLAVES(N), .SDWN_CYCLES(SD)) dut (
        .clk(clk), .rst(rst), .mtINIT(mtINIT), .mtCLRATA(mtCLRATA),
        .mtDRVCLR(mtDRVCLR), .mtGO(mtGO), .mtGOPOS(mtGOPOS), .mtDONE(mtDONE),
        .mtTMDET(mtTMDET), .mtIDBDET(mtIDBDET), .mtSEL(mtSEL),
        .sMOL(sMOL), .sWRL(sWRL), .sBOT(sBOT), .sEOT(sEOT), .sPES(sPES),
        .sDPR(sDPR), .mtER(mtER), .mtDS(mtDS), .mtRMR(mtRMR)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // phase: 0 ready, 1 moving, 2 slowing down (slow_left clocks remain)
    int  m_phase, m_slow_left;
    bit  m_pip, m_tm, m_idb, m_ata, m_rmr, m_last_err, m_last_ssc, m_primed;
    bit  m_pend [N];
    bit  m_copy [N];

    function automatic void model_reset();
        m_phase = 0; m_slow_left = 0;
        m_pip = 0; m_tm = 0; m_idb = 0; m_ata = 0; m_rmr = 0;
        m_last_err = 0; m_last_ssc = 0; m_primed = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_copy[i] = 0;
        end
    endfunction

    function automatic bit model_ssc();
        bit s = 0;
        for (int i = 0; i < N; i++) s |= m_pend[i];
        return s;
    endfunction

    // Advance the model by one clock edge using the inputs present before it.
    function automatic void model_step();
        bit err, ssc, accept, pos_done, clr;
        err = (mtER != 16'h0);
        ssc = model_ssc();
        if (mtINIT) begin
            m_phase = 0; m_slow_left = 0;
            m_pip = 0; m_tm = 0; m_idb = 0; m_ata = 0; m_rmr = 0;
            m_last_err = 0; m_last_ssc = 0;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_copy[i] = sMOL[i];
            end
            m_primed = 1;
            return;
        end
        accept   = mtGO && (m_phase == 0);
        m_rmr    = mtGO && (m_phase != 0);
        pos_done = (m_phase == 1) && mtDONE && m_pip;
        if (m_phase == 0) begin
            if (mtGO) begin
                m_phase = 1;
                m_pip   = mtGOPOS;
            end
        end else if (m_phase == 1) begin
            if (mtDONE) begin
                m_phase     = 2;
                m_slow_left = SD;
                m_pip       = 0;
            end
        end else begin
            m_slow_left--;
            if (m_slow_left == 0) m_phase = 0;
        end
        if (accept || mtDRVCLR) m_tm = 0;
        else if (mtTMDET)       m_tm = 1;
        if (accept || mtDRVCLR) m_idb = 0;
        else if (mtIDBDET)      m_idb = 1;
        clr = mtCLRATA || mtDRVCLR;
        for (int i = 0; i < N; i++) begin
            if (clr) m_pend[i] = 0;
            else if (m_primed && (sMOL[i] != m_copy[i])) m_pend[i] = 1;
            m_copy[i] = sMOL[i];
        end
        m_primed = 1;
        if (clr) m_ata = 0;
        else if ((err && !m_last_err) || (ssc && !m_last_ssc) || pos_done) m_ata = 1;
        m_last_err = err;
        m_last_ssc = ssc;
    endfunction

    function automatic logic [15:0] model_ds();
        logic [15:0] d = '0;
        int s = int'(mtSEL);
        bit ok = (s < N);
        d[DS_ATA]  = m_ata;
        d[DS_ERR]  = (mtER != 16'h0);
        d[DS_PIP]  = m_pip;
        d[DS_MOL]  = ok && sMOL[s];
        d[DS_WRL]  = ok && sWRL[s];
        d[DS_EOT]  = ok && sEOT[s];
        d[DS_DPR]  = ok && sDPR[s];
        d[DS_DRY]  = (m_phase == 0);
        d[DS_SSC]  = model_ssc();
        d[DS_PES]  = ok && sPES[s];
        d[DS_SDWN] = (m_phase == 2);
        d[DS_IDB]  = m_idb;
        d[DS_TM]   = m_tm;
        d[DS_BOT]  = ok && sBOT[s];
        d[DS_SLA]  = ok && m_pend[s];
        return d;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %06o expected %06o", tag, got, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic checki(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check16("ds", mtDS, model_ds());
        checkb("rmr", mtRMR, m_rmr);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sdwn_clks;
        model_reset();

        // Reset state
        #2;
        check16("reset_ds", mtDS, 16'o010600);
        checkb("reset_rmr", mtRMR, 1'b0);
        #10 rst = 1'b0;
        tick();
        tick();

        // Positioning command, DONE ten clocks after GO
        mtGO = 1'b1; mtGOPOS = 1'b1;
        tick();
        mtGO = 1'b0; mtGOPOS = 1'b0;
        checkb("pos_dry", mtDS[DS_DRY], 1'b0);
        checkb("pos_pip", mtDS[DS_PIP], 1'b1);
        repeat (3) tick();
        mtGO = 1'b1;
        tick();
        mtGO = 1'b0;
        checkb("rmr_busy", mtRMR, 1'b1);
        checkb("busy_pip", mtDS[DS_PIP], 1'b1);
        checkb("busy_dry", mtDS[DS_DRY], 1'b0);
        repeat (5) tick();
        mtDONE = 1'b1;
        tick();
        mtDONE = 1'b0;
        checkb("done_sdwn", mtDS[DS_SDWN], 1'b1);
        checkb("done_ata", mtDS[DS_ATA], 1'b1);
        checkb("done_pip", mtDS[DS_PIP], 1'b0);
        sdwn_clks = 1;
        for (int k = 0; k < 20 && mtDS[DS_SDWN]; k++) begin
            if (k == 1) mtGO = 1'b1;
            tick();
            mtGO = 1'b0;
            if (k == 1) checkb("rmr_slow", mtRMR, 1'b1);
            if (mtDS[DS_SDWN]) sdwn_clks++;
        end
        checki("sdwn_len", sdwn_clks, SD);
        checkb("dry_after", mtDS[DS_DRY], 1'b1);
        mtCLRATA = 1'b1;
        tick();
        mtCLRATA = 1'b0;
        checkb("ata_clr", mtDS[DS_ATA], 1'b0);

        // Slave 3 comes on line while slave 0 is selected
        sMOL = 8'h09;
        tick();
        tick();
        checkb("ssc_set", mtDS[DS_SSC], 1'b1);
        checkb("sla_sel0", mtDS[DS_SLA], 1'b0);
        checkb("ata_ssc", mtDS[DS_ATA], 1'b1);
        mtSEL = 3'd3;
        #1;
        checkb("sla_sel3", mtDS[DS_SLA], 1'b1);
        mtCLRATA = 1'b1;
        tick();
        mtCLRATA = 1'b0;
        checkb("ssc_clr", mtDS[DS_SSC], 1'b0);
        checkb("sla_clr", mtDS[DS_SLA], 1'b0);
        checkb("ata_clr2", mtDS[DS_ATA], 1'b0);

        // ERR rising with coincident clear, held, then re-armed
        mtER = 16'h0004; mtCLRATA = 1'b1;
        tick();
        mtCLRATA = 1'b0;
        checkb("err_clrwins", mtDS[DS_ATA], 1'b0);
        checkb("err_bit", mtDS[DS_ERR], 1'b1);
        tick();
        checkb("err_held", mtDS[DS_ATA], 1'b0);
        mtER = 16'h0000;
        tick();
        mtER = 16'h0010;
        tick();
        checkb("err_rerise", mtDS[DS_ATA], 1'b1);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            mtGO     = ($urandom_range(0, 5) == 0);
            mtGOPOS  = 1'($urandom);
            mtDONE   = ($urandom_range(0, 6) == 0);
            mtTMDET  = ($urandom_range(0, 9) == 0);
            mtIDBDET = ($urandom_range(0, 9) == 0);
            mtCLRATA = ($urandom_range(0, 15) == 0);
            mtDRVCLR = ($urandom_range(0, 19) == 0);
            mtINIT   = ($urandom_range(0, 49) == 0);
            mtSEL    = 3'($urandom);
            if ($urandom_range(0, 7) == 0) sMOL = sMOL ^ 8'(1 << $urandom_range(0, 7));
            sWRL = 8'($urandom); sBOT = 8'($urandom); sEOT = 8'($urandom);
            sPES = 8'($urandom); sDPR = 8'($urandom);
            if ($urandom_range(0, 5) == 0)
                mtER = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            tick();
        end
        mtGO = 0; mtGOPOS = 0; mtDONE = 0; mtTMDET = 0; mtIDBDET = 0;
        mtCLRATA = 0; mtDRVCLR = 0;
        mtINIT = 1'b1;
        tick();
        mtINIT = 1'b0;
        checkb("init_dry", mtDS[DS_DRY], 1'b1);

        // Tape mark while moving, then asynchronous reset mid slow-down
        mtGO = 1'b1;
        tick();
        mtGO = 1'b0;
        mtTMDET = 1'b1;
        tick();
        mtTMDET = 1'b0;
        checkb("tm_set", mtDS[DS_TM], 1'b1);
        tick();
        checkb("tm_hold", mtDS[DS_TM], 1'b1);
        mtDONE = 1'b1;
        tick();
        mtDONE = 1'b0;
        tick();
        checkb("tm_slow", mtDS[DS_TM], 1'b1);
        checkb("slow_sdwn", mtDS[DS_SDWN], 1'b1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        checkb("arst_dry", mtDS[DS_DRY], 1'b1);
        checkb("arst_sdwn", mtDS[DS_SDWN], 1'b0);
        checkb("arst_tm", mtDS[DS_TM], 1'b0);
        check16("arst_ds", mtDS, model_ds());
        checkb("arst_rmr", mtRMR, 1'b0);
        #3 rst = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
